lpf_frame_writer: RTL and testbench

- Upstream producer for the sequential low-pass-filter frame buffer. Accepts one 18-bit truncated pixel per `pixel_valid` from the video capture path.
- Packs each horizontally adjacent even/odd pixel pair into one 36-bit memory word. The even pixel goes in [35:18], the odd pixel in [17:0], which is the layout the LPF reader unpacks.
- Queues packed words in a small FIFO and writes them to the memory interface with a flag/done handshake, one word per transaction.

---
 rtl/lpf_frame_writer.sv | 189 ++++++++++++++++++
 tb/tb_lpf_frame_writer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpf_frame_writer.sv
// Packs even/odd 18-bit pixel pairs into 36-bit words, queues them in a small
// FIFO and writes them to memory one word per flag/done transaction.
//
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   frame_start        pulse: restart input counters, flush unissued words
//   pixel_in/valid     incoming 18-bit pixel stream
//   wr_flag, wr        memory write request (held until done)
//   wr_x, wr_y         coordinates of the even pixel of the word
//   wr_data            {even, odd} pixel pair
//   done               one-cycle memory acknowledge
//   fifo_count         queued words, including the one in flight
//   overflow           sticky: a word was dropped on a full FIFO
//   frame_done         pulse when the frame's last word is written
module lpf_frame_writer #(
   parameter int WIDTH      = 640,
   parameter int HEIGHT     = 480,
   parameter int FIFO_DEPTH = 8,
   parameter int LOG_FIFO   = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                frame_start,
   input  logic [17:0]         pixel_in,
   input  logic                pixel_valid,
   output logic                wr_flag,
   output logic                wr,
   output logic [9:0]          wr_x,
   output logic [8:0]          wr_y,
   output logic [35:0]         wr_data,
   input  logic                done,
   output logic [LOG_FIFO:0]   fifo_count,
   output logic                overflow,
   output logic                frame_done
);

   typedef enum logic {IDLE, REQ} state_t;

   typedef struct packed {
      logic [9:0]  x;
      logic [8:0]  y;
      logic [35:0] d;
   } ent_t;

   localparam logic [LOG_FIFO:0] DEPTH_C = (LOG_FIFO+1)'(FIFO_DEPTH);

   state_t              state_q;
   logic                flag_q;
   logic [9:0]          wx_q;
   logic [8:0]          wy_q;
   logic [35:0]         wd_q;
   logic                fdone_q;
   logic                ldrop_q;
   logic                ovf_q;

   logic [9:0]          x_q;
   logic [8:0]          y_q;
   logic [17:0]         hold_q;
   logic                fend_q;

   ent_t                mem_q [FIFO_DEPTH];
   logic [LOG_FIFO-1:0] rd_q, rd_d;
   logic [LOG_FIFO-1:0] wp_q, wp_d;
   logic [LOG_FIFO:0]   cnt_q, cnt_d;

   logic accept, push, pop, full, drop, store, last_pix, keep;

   assign accept   = pixel_valid && !frame_start && !fend_q;
   assign push     = accept && x_q[0];
   assign pop      = (state_q == REQ) && done;
   assign full     = (cnt_q == DEPTH_C);
   assign drop     = push && full && !pop;
   assign store    = push && !drop;
   assign last_pix = (x_q == 10'(WIDTH-1)) && (y_q == 9'(HEIGHT-1));

   // An in-flight word survives a flush unless it is acknowledged now.
   always_comb begin
      rd_d  = rd_q;
      wp_d  = wp_q;
      cnt_d = cnt_q;
      keep  = 1'b0;
      if (pop) rd_d = rd_q + 1'b1;
      if (frame_start) begin
         keep  = (state_q == REQ) && !done;
         wp_d  = rd_d + LOG_FIFO'(keep);
         cnt_d = (LOG_FIFO+1)'(keep);
      end else begin
         if (store) wp_d = wp_q + 1'b1;
         cnt_d = cnt_q + (LOG_FIFO+1)'(store)
               - (LOG_FIFO+1)'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (store) mem_q[wp_q] <= '{x: {x_q[9:1], 1'b0},
                                  y: y_q,
                                  d: {hold_q, pixel_in}};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         x_q    <= '0;
         y_q    <= '0;
         hold_q <= '0;
         fend_q <= 1'b0;
         rd_q   <= '0;
         wp_q   <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         rd_q  <= rd_d;
         wp_q  <= wp_d;
         cnt_q <= cnt_d;
         if (drop) ovf_q <= 1'b1;
         if (frame_start) begin
            x_q    <= '0;
            y_q    <= '0;
            hold_q <= '0;
            fend_q <= 1'b0;
         end else if (accept) begin
            if (!x_q[0]) hold_q <= pixel_in;
            if (x_q == 10'(WIDTH-1)) begin
               x_q <= '0;
               if (y_q == 9'(HEIGHT-1)) begin
                  y_q    <= '0;
                  fend_q <= 1'b1;
               end else begin
                  y_q <= y_q + 1'b1;
               end
            end else begin
               x_q <= x_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         flag_q  <= 1'b0;
         wx_q    <= '0;
         wy_q    <= '0;
         wd_q    <= '0;
         fdone_q <= 1'b0;
         ldrop_q <= 1'b0;
      end else begin
         fdone_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (cnt_q != '0 && !frame_start) begin
                  wx_q    <= mem_q[rd_q].x;
                  wy_q    <= mem_q[rd_q].y;
                  wd_q    <= mem_q[rd_q].d;
                  flag_q  <= 1'b1;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (done) begin
                  flag_q  <= 1'b0;
                  state_q <= IDLE;
                  if (wx_q == 10'(WIDTH-2) && wy_q == 9'(HEIGHT-1))
                     fdone_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
         // Last word lost: report the frame once the queue has drained.
         if (frame_start) begin
            ldrop_q <= 1'b0;
         end else if (drop && last_pix) begin
            ldrop_q <= 1'b1;
         end else if (ldrop_q && fend_q && cnt_q == '0 && state_q == IDLE) begin
            ldrop_q <= 1'b0;
            fdone_q <= 1'b1;
         end
      end
   end

   assign wr_flag    = flag_q;
   assign wr         = flag_q;
   assign wr_x       = wx_q;
   assign wr_y       = wy_q;
   assign wr_data    = wd_q;
   assign fifo_count = cnt_q;
   assign overflow   = ovf_q;
   assign frame_done = fdone_q;

endmodule

// File: tb/tb_lpf_frame_writer.sv
// Self-checking bench for lpf_frame_writer: a full-size instance checked
// against a queue model of the pixel stream, plus a 4x2 instance.
module tb_lpf_frame_writer;

   localparam int DEPTH = 8;
   localparam int W     = 640;
   localparam int H     = 480;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        frame_start = 1'b0;
   logic [17:0] pixel_in = '0;
   logic        pixel_valid = 1'b0;
   logic        wr_flag, wr;
   logic [9:0]  wr_x;
   logic [8:0]  wr_y;
   logic [35:0] wr_data;
   logic        done = 1'b0;
   logic [3:0]  fifo_count;
   logic        overflow, frame_done;

   logic        s_frame_start = 1'b0;
   logic [17:0] s_pixel_in = '0;
   logic        s_pixel_valid = 1'b0;
   logic        s_wr_flag, s_wr;
   logic [9:0]  s_wr_x;
   logic [8:0]  s_wr_y;
   logic [35:0] s_wr_data;
   logic        s_done = 1'b0;
   logic [3:0]  s_fifo_count;
   logic        s_overflow, s_frame_done;

   always #5 clock = ~clock;

   lpf_frame_writer dut (
      .clock(clock), .reset(reset), .frame_start(frame_start),
      .pixel_in(pixel_in), .pixel_valid(pixel_valid),
      .wr_flag(wr_flag), .wr(wr), .wr_x(wr_x), .wr_y(wr_y),
      .wr_data(wr_data), .done(done), .fifo_count(fifo_count),
      .overflow(overflow), .frame_done(frame_done)
   );

   lpf_frame_writer #(.WIDTH(4), .HEIGHT(2)) sdut (
      .clock(clock), .reset(reset), .frame_start(s_frame_start),
      .pixel_in(s_pixel_in), .pixel_valid(s_pixel_valid),
      .wr_flag(s_wr_flag), .wr(s_wr), .wr_x(s_wr_x), .wr_y(s_wr_y),
      .wr_data(s_wr_data), .done(s_done), .fifo_count(s_fifo_count),
      .overflow(s_overflow), .frame_done(s_frame_done)
   );

   int passed = 0;
   int total  = 0;

   // model of the main instance: words stored but not yet acknowledged
   logic [54:0] exp_q [$];
   logic [54:0] got_log [$];
   logic [54:0] s_got_q [$];
   int          mx = 0, my = 0, mfend = 0;
   logic [17:0] held = '0;
   int          nwr = 0, s_fd = 0;
   int          lat = 0, wc = 0;
   bit          hold = 1'b0;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   task automatic step();
      bit          ack, infl, fs, rs, sack;
      logic [54:0] got, sgot;
      ack  = done && wr_flag;
      infl = wr_flag;
      fs   = frame_start;
      rs   = reset;
      got  = {wr_x, wr_y, wr_data};
      sack = s_done && s_wr_flag;
      sgot = {s_wr_x, s_wr_y, s_wr_data};
      @(posedge clock);
      #1;
      if (rs) begin
         exp_q.delete();
         mx = 0; my = 0; mfend = 0; held = '0;
      end else begin
         if (ack) begin
            nwr++;
            got_log.push_back(got);
            check("wr_expected", 64'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("wr_word", got, exp_q.pop_front());
         end
         if (fs) begin
            mx = 0; my = 0; mfend = 0; held = '0;
            if (infl && !ack && exp_q.size() > 0) exp_q = exp_q[0:0];
            else exp_q.delete();
         end
      end
      if (sack) s_got_q.push_back(sgot);
      if (s_frame_done) s_fd++;
      if (done) begin
         done = 1'b0; wc = 0;
      end else if (wr_flag && !hold) begin
         if (wc >= lat) done = 1'b1;
         else wc++;
      end else begin
         wc = 0;
      end
      s_done = s_wr_flag && !s_done;
   endtask

   task automatic pix(logic [17:0] v);
      bit ack;
      pixel_in    = v;
      pixel_valid = 1'b1;
      if (!frame_start && mfend == 0) begin
         if (mx % 2 == 0) begin
            held = v;
         end else begin
            ack = done && wr_flag;
            if (!(exp_q.size() == DEPTH && !ack))
               exp_q.push_back({10'(mx-1), 9'(my), held, v});
         end
         if (mx == W-1) begin
            mx = 0;
            if (my == H-1) begin my = 0; mfend = 1; end
            else my++;
         end else begin
            mx++;
         end
      end
      step();
      pixel_valid = 1'b0;
   endtask

   task automatic fstart();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && (exp_q.size() != 0 || wr_flag); i++)
         step();
      check("drain_empty", 64'(exp_q.size()), 0);
   endtask

   task automatic s_pix(logic [17:0] v);
      s_pixel_in    = v;
      s_pixel_valid = 1'b1;
      step();
      s_pixel_valid = 1'b0;
   endtask

   initial begin
      logic [17:0] a, b;
      logic [17:0] sp [9];
      int          n0;

      step(); step();
      reset = 1'b0;
      check("reset_outs", {wr_flag, wr, wr_x, wr_y, wr_data,
                           fifo_count, overflow, frame_done}, 0);
      check("s_reset_outs", {s_wr_flag, s_fifo_count, s_frame_done}, 0);

      // two words with a slow memory
      lat = 2;
      fstart();
      pix(18'h00001); pix(18'h00002); pix(18'h00003); pix(18'h00004);
      drain();
      check("t1_nwr", 64'(nwr), 2);
      check("t1_w0", got_log[0], {10'd0, 9'd0, 36'h000040002});
      check("t1_w1", got_log[1], {10'd2, 9'd0, 36'h0000C0004});
      check("t1_count", 64'(fifo_count), 0);
      check("t1_ovf", 64'(overflow), 0);

      // one full line with immediate acknowledge
      lat = 0;
      fstart();
      n0 = nwr;
      for (int i = 0; i < W; i++) begin
         pix(18'($urandom));
         step();
      end
      drain();
      check("t2_nwr", 64'(nwr - n0), W/2);
      check("t2_last_x", 64'(got_log[got_log.size()-1][54:45]), W-2);
      a = 18'($urandom); b = 18'($urandom);
      pix(a); pix(b);
      drain();
      check("t2_wrap", got_log[got_log.size()-1], {10'd0, 9'd1, a, b});
      check("t2_ovf", 64'(overflow), 0);

      // memory stalled: FIFO fills and later words are dropped
      hold = 1'b1;
      n0 = nwr;
      for (int i = 0; i < 20; i++) pix(18'($urandom));
      step();
      check("t3_count", 64'(fifo_count), DEPTH);
      check("t3_ovf", 64'(overflow), 1);
      check("t3_model", 64'(exp_q.size()), DEPTH);
      hold = 1'b0;
      drain();
      check("t3_nwr", 64'(nwr - n0), DEPTH);
      check("t3_count0", 64'(fifo_count), 0);

      // 4x2 frame on the small instance
      s_frame_start = 1'b1; step(); s_frame_start = 1'b0;
      for (int i = 0; i < 9; i++) sp[i] = 18'($urandom);
      for (int i = 0; i < 8; i++) s_pix(sp[i]);
      for (int i = 0; i < 20; i++) step();
      check("t4_nwr", 64'(s_got_q.size()), 4);
      check("t4_w0", s_got_q[0], {10'd0, 9'd0, sp[0], sp[1]});
      check("t4_w3", s_got_q[3], {10'd2, 9'd1, sp[6], sp[7]});
      check("t4_fdone", 64'(s_fd), 1);
      s_pix(sp[8]);
      s_pix(sp[0]);
      for (int i = 0; i < 10; i++) step();
      check("t4_ignored", 64'(s_got_q.size()), 4);
      check("t4_scount", 64'(s_fifo_count), 0);
      s_frame_start = 1'b1; step(); s_frame_start = 1'b0;
      s_pix(sp[2]); s_pix(sp[3]);
      for (int i = 0; i < 10; i++) step();
      check("t4_restart", s_got_q[s_got_q.size()-1],
            {10'd0, 9'd0, sp[2], sp[3]});
      check("t4_fdone_once", 64'(s_fd), 1);

      // frame_start while a request is in flight
      hold = 1'b1;
      fstart();
      for (int i = 0; i < 6; i++) pix(18'($urandom));
      step();
      check("t5_req", 64'(wr_flag), 1);
      check("t5_count3", 64'(fifo_count), 3);
      fstart();
      check("t5_count1", 64'(fifo_count), 1);
      n0 = nwr;
      hold = 1'b0;
      for (int i = 0; i < 20; i++) step();
      check("t5_inflight", 64'(nwr - n0), 1);
      check("t5_count0", 64'(fifo_count), 0);
      a = 18'($urandom); b = 18'($urandom);
      pix(a); pix(b);
      drain();
      check("t5_restart", got_log[got_log.size()-1], {10'd0, 9'd0, a, b});

      // reset during a request, then a stray done
      hold = 1'b1;
      pix(18'($urandom)); pix(18'($urandom));
      for (int i = 0; i < 10 && !wr_flag; i++) step();
      check("t6_req", 64'(wr_flag), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t6_reset_outs", {wr_flag, wr, wr_x, wr_y, wr_data,
                              fifo_count, overflow, frame_done}, 0);
      n0 = nwr;
      done = 1'b1;
      step();
      for (int i = 0; i < 5; i++) step();
      check("t6_count", 64'(fifo_count), 0);
      check("t6_flag", 64'(wr_flag), 0);
      check("t6_nwr", 64'(nwr - n0), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
